// File: rtl/hazard_scoreboard.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects, load-use and
// multi-cycle RAW/WAW/structural stalls, branch flush and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int MD_LAT     = 4,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic                  id_regwrite,
    input  logic [REG_ADDR_W-1:0] id_wreg,
    input  logic                  id_is_md,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_memread,
    input  logic                  ex_regwrite,
    input  logic [REG_ADDR_W-1:0] ex_wreg,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] mem_wreg,
    input  logic                  wb_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_wreg,
    input  logic                  branch_taken,
    output logic                  stall,
    output logic                  bubble,
    output logic                  flush,
    output logic [1:0]            fwd_rs,
    output logic [1:0]            fwd_rt,
    output logic                  md_busy,
    output logic                  md_done,
    output logic [REG_ADDR_W-1:0] md_wreg,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [3:0]       MD_LAT_C = 4'(MD_LAT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [3:0]            md_cnt_q, md_cnt_d;
    logic                  md_busy_q, md_busy_d;
    logic [REG_ADDR_W-1:0] md_wreg_q, md_wreg_d;
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic load_use, nofwd_raw, md_raw, md_waw, md_struct, hz, md_issue;

    // A used, nonzero ID source register equal to r.
    function automatic logic src_match(input logic [REG_ADDR_W-1:0] r);
        return (id_uses_rs && id_rs != '0 && id_rs == r) ||
               (id_uses_rt && id_rt != '0 && id_rt == r);
    endfunction

    always_comb begin
        fwd_rs = 2'b00;
        fwd_rt = 2'b00;
        if (FWD_EN != 0 && !rst) begin
            if (mem_regwrite && mem_wreg != '0 && mem_wreg == ex_rs)
                fwd_rs = 2'b01;
            else if (wb_regwrite && wb_wreg != '0 && wb_wreg == ex_rs)
                fwd_rs = 2'b10;
            if (mem_regwrite && mem_wreg != '0 && mem_wreg == ex_rt)
                fwd_rt = 2'b01;
            else if (wb_regwrite && wb_wreg != '0 && wb_wreg == ex_rt)
                fwd_rt = 2'b10;
        end
    end

    // Without forwarding, any in-flight writer blocks a reader; the register file is not write-through.
    always_comb begin
        load_use  = id_valid && ex_memread && ex_regwrite && src_match(ex_wreg);
        nofwd_raw = (FWD_EN == 0) && id_valid &&
                    ((ex_regwrite  && src_match(ex_wreg))  ||
                     (mem_regwrite && src_match(mem_wreg)) ||
                     (wb_regwrite  && src_match(wb_wreg)));
        md_raw    = id_valid && md_busy_q && src_match(md_wreg_q);
        md_waw    = id_valid && md_busy_q && id_regwrite && (id_wreg == md_wreg_q);
        md_struct = id_valid && md_busy_q && id_is_md;
        hz        = load_use || nofwd_raw || md_raw || md_waw || md_struct;
        stall     = !rst && hz && !branch_taken;
        bubble    = !rst && (hz || branch_taken);
        flush     = !rst && branch_taken;
        md_done   = !rst && md_busy_q && (md_cnt_q == 4'd1);
        md_issue  = id_valid && id_is_md && !stall && !branch_taken;
    end

    always_comb begin
        md_cnt_d    = md_cnt_q;
        md_busy_d   = md_busy_q;
        md_wreg_d   = md_wreg_q;
        stall_cnt_d = stall_cnt_q;
        if (md_issue) begin
            md_cnt_d  = MD_LAT_C;
            md_busy_d = 1'b1;
            md_wreg_d = id_wreg;
        end else if (md_busy_q) begin
            if (md_cnt_q == 4'd1) begin
                md_cnt_d  = 4'd0;
                md_busy_d = 1'b0;
            end else begin
                md_cnt_d  = md_cnt_q - 4'd1;
            end
        end
        if (stall && stall_cnt_q != CNT_MAX)
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q    <= 4'd0;
            md_busy_q   <= 1'b0;
            md_wreg_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            md_busy_q   <= md_busy_d;
            md_wreg_q   <= md_wreg_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign md_busy   = md_busy_q;
    assign md_wreg   = md_wreg_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a default instance plus a no-forwarding,
// 4-bit-counter instance driven by the same pipeline inputs.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_rs, id_uses_rt, id_regwrite, id_is_md;
    logic [4:0] id_rs, id_rt, id_wreg, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       ex_memread, ex_regwrite, mem_regwrite, wb_regwrite, branch_taken;

    logic        stall, bubble, flush, md_busy, md_done;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [4:0]  md_wreg;
    logic [15:0] stall_cnt;

    logic        stall2, bubble2, flush2, md_busy2, md_done2;
    logic [1:0]  fwd_rs2, fwd_rt2;
    logic [4:0]  md_wreg2;
    logic [3:0]  stall_cnt2;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(5), .MD_LAT(4), .FWD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_wreg(id_wreg), .id_is_md(id_is_md), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite),
        .wb_wreg(wb_wreg), .branch_taken(branch_taken), .stall(stall), .bubble(bubble),
        .flush(flush), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy),
        .md_done(md_done), .md_wreg(md_wreg), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.REG_ADDR_W(5), .MD_LAT(4), .FWD_EN(0), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_regwrite(id_regwrite),
        .id_wreg(id_wreg), .id_is_md(id_is_md), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_wreg(ex_wreg),
        .mem_regwrite(mem_regwrite), .mem_wreg(mem_wreg), .wb_regwrite(wb_regwrite),
        .wb_wreg(wb_wreg), .branch_taken(branch_taken), .stall(stall2), .bubble(bubble2),
        .flush(flush2), .fwd_rs(fwd_rs2), .fwd_rt(fwd_rt2), .md_busy(md_busy2),
        .md_done(md_done2), .md_wreg(md_wreg2), .stall_cnt(stall_cnt2)
    );

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_regwrite = 0; id_is_md = 0;
        id_rs = 0; id_rt = 0; id_wreg = 0; ex_rs = 0; ex_rt = 0; ex_wreg = 0;
        mem_wreg = 0; wb_wreg = 0; ex_memread = 0; ex_regwrite = 0;
        mem_regwrite = 0; wb_regwrite = 0; branch_taken = 0;
    endtask

    // Advance one clock and let registered outputs settle.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clearInputs();
        rst = 1;
        // Hazard-looking inputs while in reset: everything must read as idle
        branch_taken = 1; mem_regwrite = 1; mem_wreg = 3; ex_rs = 3;
        #1;
        checkOutput("rst_flush", 16'(flush), 16'd0);
        checkOutput("rst_bubble", 16'(bubble), 16'd0);
        checkOutput("rst_fwd_rs", 16'(fwd_rs), 16'd0);
        applyStimulus();
        applyStimulus();
        checkOutput("rst_md_busy", 16'(md_busy), 16'd0);
        checkOutput("rst_stall_cnt", 16'(stall_cnt), 16'd0);
        rst = 0;
        clearInputs();

        // Forwarding priority: EX/MEM over MEM/WB, register 0 never forwarded
        mem_regwrite = 1; mem_wreg = 3; wb_regwrite = 1; wb_wreg = 3; ex_rs = 3; ex_rt = 3;
        #1;
        checkOutput("fwd_rs_mem", 16'(fwd_rs), 16'd1);
        checkOutput("fwd_rt_mem", 16'(fwd_rt), 16'd1);
        checkOutput("fwd_stall", 16'(stall), 16'd0);
        checkOutput("fwd_rs_nofwd", 16'(fwd_rs2), 16'd0);
        mem_wreg = 0;
        #1;
        checkOutput("fwd_rs_wb", 16'(fwd_rs), 16'd2);
        wb_wreg = 0;
        #1;
        checkOutput("fwd_rs_none", 16'(fwd_rs), 16'd0);
        applyStimulus();
        clearInputs();

        // Load-use: one stall cycle, then the bubble sits in ID/EX
        id_valid = 1; id_uses_rs = 1; id_rs = 5;
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 5;
        #1;
        checkOutput("lu_stall", 16'(stall), 16'd1);
        checkOutput("lu_bubble", 16'(bubble), 16'd1);
        checkOutput("lu_cnt_before", 16'(stall_cnt), 16'd0);
        applyStimulus();
        ex_memread = 0; ex_regwrite = 0; ex_wreg = 0;
        #1;
        checkOutput("lu_stall_after", 16'(stall), 16'd0);
        checkOutput("lu_cnt_after", 16'(stall_cnt), 16'd1);
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 5; id_rs = 0;
        #1;
        checkOutput("lu_r0_stall", 16'(stall), 16'd0);
        checkOutput("lu_r0_bubble", 16'(bubble), 16'd0);
        applyStimulus();
        clearInputs();

        // MD op to r7, followed by a reader of r7
        id_valid = 1; id_is_md = 1; id_regwrite = 1; id_wreg = 7;
        #1;
        checkOutput("md_issue_stall", 16'(stall), 16'd0);
        applyStimulus();
        id_is_md = 0; id_regwrite = 0; id_wreg = 0; id_uses_rs = 1; id_rs = 7;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checkOutput($sformatf("md_busy_c%0d", k), 16'(md_busy), 16'd1);
            checkOutput($sformatf("md_raw_stall_c%0d", k), 16'(stall), 16'd1);
            checkOutput($sformatf("md_done_c%0d", k), 16'(md_done), (k == 4) ? 16'd1 : 16'd0);
            applyStimulus();
        end
        checkOutput("md_wreg", 16'(md_wreg), 16'd7);
        checkOutput("md_busy_end", 16'(md_busy), 16'd0);
        checkOutput("md_reader_go", 16'(stall), 16'd0);
        checkOutput("md_cnt_5", 16'(stall_cnt), 16'd5);
        applyStimulus();

        // Back-to-back MD ops: the second waits out the first (structural)
        id_uses_rs = 0; id_rs = 0; id_is_md = 1; id_regwrite = 1; id_wreg = 8;
        #1;
        checkOutput("md2a_issue", 16'(stall), 16'd0);
        applyStimulus();
        id_wreg = 9;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checkOutput($sformatf("md2b_stall_c%0d", k), 16'(stall), 16'd1);
            checkOutput($sformatf("md2b_done_c%0d", k), 16'(md_done), (k == 4) ? 16'd1 : 16'd0);
            applyStimulus();
        end
        checkOutput("md2b_go", 16'(stall), 16'd0);
        checkOutput("md2b_cnt_9", 16'(stall_cnt), 16'd9);
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("md2b_busy", 16'(md_busy), 16'd1);
        checkOutput("md2b_wreg", 16'(md_wreg), 16'd9);

        // Reset in the second cycle of an in-flight op abandons it
        applyStimulus();
        rst = 1;
        #1;
        checkOutput("mdrst_done_forced", 16'(md_done), 16'd0);
        applyStimulus();
        rst = 0;
        #1;
        checkOutput("mdrst_busy", 16'(md_busy), 16'd0);
        checkOutput("mdrst_cnt", 16'(stall_cnt), 16'd0);
        for (int k = 1; k <= 4; k++) begin
            checkOutput($sformatf("mdrst_nodone_c%0d", k), 16'(md_done), 16'd0);
            applyStimulus();
        end

        // Taken branch beats a load-use hazard and drops the MD op in ID
        id_valid = 1; id_uses_rs = 1; id_rs = 5; id_is_md = 1; id_regwrite = 1; id_wreg = 10;
        ex_memread = 1; ex_regwrite = 1; ex_wreg = 5; branch_taken = 1;
        #1;
        checkOutput("br_stall", 16'(stall), 16'd0);
        checkOutput("br_bubble", 16'(bubble), 16'd1);
        checkOutput("br_flush", 16'(flush), 16'd1);
        applyStimulus();
        clearInputs();
        #1;
        checkOutput("br_md_busy", 16'(md_busy), 16'd0);
        checkOutput("br_cnt", 16'(stall_cnt), 16'd0);

        // No-forward instance stalls on a MEM/WB writer; then counter saturation
        wb_regwrite = 1; wb_wreg = 9; ex_rt = 9; id_valid = 1; id_uses_rt = 1; id_rt = 9;
        #1;
        checkOutput("nf_stall", 16'(stall2), 16'd1);
        checkOutput("nf_fwd_rt", 16'(fwd_rt2), 16'd0);
        checkOutput("fw_stall", 16'(stall), 16'd0);
        checkOutput("fw_fwd_rt", 16'(fwd_rt), 16'd2);
        for (int k = 1; k <= 19; k++) begin
            applyStimulus();
            if (k == 14) checkOutput("sat_cnt_14", 16'(stall_cnt2), 16'd14);
        end
        checkOutput("sat_cnt_max", 16'(stall_cnt2), 16'd15);
        checkOutput("sat_fw_cnt", 16'(stall_cnt), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
